// File: rtl/uart_pkg.sv
// Shared UART definitions: deframer state encoding, frame geometry
// and bit-period counter sizing used by the RX path and, later, the TX path.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Counter holds values 0 .. bit_cycles-1
  function automatic int cnt_width(input int bit_cycles);
    return (bit_cycles < 2) ? 1 : $clog2(bit_cycles);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word fall-through head and drop reporting.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop on the same edge frees the slot the push lands in
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;

  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, bit-period deframer,
// byte FIFO with valid/ready pop and sticky overrun/framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 347,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_core,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 overrun,
  output logic                 frame_err,
  input  logic                 err_clear,
  output logic                 busy
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_busy;
  logic                 r_overrun;
  logic                 r_frame_err;

  logic w_expire;
  logic w_stop_hit;
  logic w_push;
  logic w_ferr_set;
  logic w_empty;
  logic w_full;
  logic w_drop;

  assign w_expire   = (r_cnt == '0);
  assign w_stop_hit = (r_state == ST_STOP) && w_expire;
  assign w_push     = w_stop_hit & r_sync2;
  assign w_ferr_set = w_stop_hit & ~r_sync2;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!r_sync2) begin
            r_cnt   <= HALF_M1;
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_sync2) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt     <= FULL_M1;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            r_cnt   <= FULL_M1;
            if (r_bit_idx == 3'(DATA_BITS - 1)) r_state <= ST_STOP;
            else r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        ST_STOP: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= r_sync2 ? ST_IDLE : ST_BREAK;
            r_busy  <= ~r_sync2;
          end
        end
        ST_BREAK: begin
          // Held-low line must return high before a new start is seen
          if (r_sync2) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)         r_overrun <= 1'b1;
      else if (err_clear) r_overrun <= 1'b0;
      if (w_ferr_set)     r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk_core),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (rd_ready),
    .o_rdata (rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign rd_valid  = ~w_empty;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences and
// random frames against a queue-based model of the receive path.
module tb_uart_rx;

  localparam int B = 16;
  localparam int D = 4;
  // rx falls after edge 0; 2 sync edges, 1 decision edge, half bit, 9 bits
  localparam int RISE = 2 + 1 + B / 2 + 9 * B;

  logic       clk_core = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       overrun;
  logic       frame_err;
  logic       err_clear = 1'b0;
  logic       busy;

  int total = 0;
  int bad = 0;

  always #5 clk_core = ~clk_core;

  uart_rx #(
    .BIT_CYCLES (B),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_core  (clk_core),
    .reset_n   (reset_n),
    .rx        (rx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clear (err_clear),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] d;
    bit         ok;
    int         rise;
    bit         ferr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  // Drives one 8N1 frame; edge k is the posedge before bit slot k changes
  task automatic send(input logic [7:0] d, input bit stop_ok,
                      input int pop_k, output int rise_k,
                      output logic [7:0] pop_data);
    logic [9:0] fr;
    bit prev;
    fr = {stop_ok, d, 1'b0};
    rise_k = -1;
    pop_data = 8'h00;
    prev = rd_valid;
    for (int k = 0; k < 10 * B; k++) begin
      @(posedge clk_core);
      #1;
      rx = fr[k / B];
      rd_ready = (k == pop_k);
      @(negedge clk_core);
      if (k == pop_k) pop_data = rd_data;
      if (rd_valid && !prev && rise_k < 0) rise_k = k;
      prev = rd_valid;
    end
    @(posedge clk_core);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    @(negedge clk_core);
    chk({nm, " valid"}, rd_valid, 1);
    chk({nm, " data"}, rd_data, exp);
    rd_ready = 1'b1;
    @(posedge clk_core);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk_core);
    err_clear = 1'b1;
    @(posedge clk_core);
    #1;
    err_clear = 1'b0;
  endtask

  task automatic line_high(input int n);
    @(posedge clk_core);
    #1;
    rx = 1'b1;
    wait_cyc(n);
  endtask

  initial begin
    vec_t       tbl[5];
    int         rk;
    logic [7:0] pd;
    bit         seen;
    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_ferr;

    tbl[0] = '{8'hA5, 1'b1, RISE, 1'b0};
    tbl[1] = '{8'h00, 1'b1, RISE, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, RISE, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, -1, 1'b1};
    tbl[4] = '{8'h81, 1'b1, RISE, 1'b0};

    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    chk("rst frame_err", frame_err, 0);
    @(posedge clk_core);
    #1;
    reset_n = 1'b1;
    wait_cyc(4);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].d, tbl[i].ok, -1, rk, pd);
      if (!tbl[i].ok) line_high(6);
      chk($sformatf("vec%0d rise", i), rk, tbl[i].rise);
      chk($sformatf("vec%0d ferr", i), frame_err, tbl[i].ferr);
      chk($sformatf("vec%0d ovr", i), overrun, 0);
      if (tbl[i].ok) pop_chk($sformatf("vec%0d", i), tbl[i].d);
      @(negedge clk_core);
      chk($sformatf("vec%0d empty", i), rd_valid, 0);
      clear_err();
    end

    // Short low glitch: START sample sees high again
    @(posedge clk_core);
    #1;
    rx = 1'b0;
    wait_cyc(6);
    rx = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_core);
      if (busy) seen = 1'b1;
    end
    chk("glitch busy seen", seen, 1);
    chk("glitch busy end", busy, 0);
    chk("glitch valid", rd_valid, 0);
    chk("glitch ferr", frame_err, 0);
    chk("glitch ovr", overrun, 0);

    // Bad stop bit then held-low line
    send(8'h3C, 1'b0, -1, rk, pd);
    wait_cyc(40);
    @(negedge clk_core);
    chk("break busy", busy, 1);
    chk("break ferr", frame_err, 1);
    line_high(6);
    send(8'h81, 1'b1, -1, rk, pd);
    chk("break rise", rk, RISE);
    pop_chk("break byte", 8'h81);
    @(negedge clk_core);
    chk("break empty", rd_valid, 0);
    clear_err();

    // Overrun: fifth byte dropped
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, -1, rk, pd);
      if (i == 4) chk("ovr before", overrun, 0);
    end
    chk("ovr set", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovr pop%0d", i), 8'(i));
    @(negedge clk_core);
    chk("ovr empty", rd_valid, 0);
    clear_err();
    @(negedge clk_core);
    chk("ovr cleared", overrun, 0);

    // Full FIFO with a pop on the push edge
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, -1, rk, pd);
    send(8'h05, 1'b1, RISE - 1, rk, pd);
    chk("fullpop head", pd, 8'h01);
    chk("fullpop ovr", overrun, 0);
    for (int i = 2; i <= 5; i++) pop_chk($sformatf("fullpop %0d", i), 8'(i));
    @(negedge clk_core);
    chk("fullpop empty", rd_valid, 0);

    // Reset mid-frame discards the partial byte
    @(posedge clk_core);
    #1;
    rx = 1'b0;
    wait_cyc(40);
    @(negedge clk_core);
    chk("midrst busy", busy, 1);
    @(posedge clk_core);
    #1;
    reset_n = 1'b0;
    rx = 1'b1;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(5);
    @(negedge clk_core);
    chk("midrst idle", busy, 0);
    chk("midrst valid", rd_valid, 0);
    send(8'h55, 1'b1, -1, rk, pd);
    chk("midrst rise", rk, RISE);
    pop_chk("midrst byte", 8'h55);
    @(negedge clk_core);
    chk("midrst empty", rd_valid, 0);
    chk("midrst flags", {overrun, frame_err}, 0);

    // err_clear takes effect on the next edge
    send(8'h3C, 1'b0, -1, rk, pd);
    line_high(6);
    @(negedge clk_core);
    chk("clr pre", frame_err, 1);
    err_clear = 1'b1;
    @(posedge clk_core);
    #1;
    err_clear = 1'b0;
    @(negedge clk_core);
    chk("clr post", frame_err, 0);

    // Random frames against a queue model
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit ok;
      bit was_empty;
      int npop;
      d = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) begin
        clear_err();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
      end
      was_empty = (mq.size() == 0);
      send(d, ok, -1, rk, pd);
      if (!ok) line_high(6);
      if (ok) begin
        if (mq.size() < D) mq.push_back(d);
        else m_ovr = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      if (was_empty)
        chk($sformatf("rnd%0d rise", n), rk, ok ? RISE : -1);
      @(negedge clk_core);
      chk($sformatf("rnd%0d ovr", n), overrun, m_ovr);
      chk($sformatf("rnd%0d ferr", n), frame_err, m_ferr);
      npop = $urandom_range(0, 3);
      for (int j = 0; j < npop; j++) begin
        if (mq.size() > 0) pop_chk($sformatf("rnd%0d pop", n), mq.pop_front());
      end
    end
    while (mq.size() > 0) pop_chk("rnd drain", mq.pop_front());
    @(negedge clk_core);
    chk("rnd empty", rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
